multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- A Moore FSM sequences each instruction over 3–5 states and drives every datapath mux, enable and ALUOp in the multi-cycle MIPS datapath.
- Adds a memory ready/wait handshake, addi and j support, and illegal-opcode detection with a selectable trap mode.
- Sits between the instruction register opcode field and the shared-memory multi-cycle datapath.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 2, ALUOp width (00 add, 01 sub, 10 funct-decode, 11 reserved).
- TRAP_ON_ILLEGAL, 0. 0: pulse illegal_op and resume fetch. 1: enter HALT until reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  instruction register [31:26]; sampled in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero.
- IorD  out  1  memory address select (0 PC, 1 ALUOut).
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- MemtoReg  out  1  write-back select (1 MDR).
- IRWrite  out  1  instruction register load.
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target.
- ALUOp  out  ALUOP_W  ALU control class.
- ALUSrcA  out  1  0 PC, 1 reg A.
- ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- RegWrite  out  1  register file write.
- RegDst  out  1  1 rd, 0 rt.
- illegal_op  out  1  one-cycle pulse on unrecognised opcode.
- halted  out  1  high while in HALT.
- state  out  4  current state encoding, for debug and bench.

Behaviour:
- **Reset:** rst_n low asynchronously forces state=RESET; every output reads 0. The first clock with rst_n high moves RESET→FETCH. Reset asserted mid-instruction aborts with no further outputs; no partial write is held.
- **Output timing:** outputs are decoded from the registered state only, except that IRWrite/PCWrite in FETCH are qualified by mem_ready. All unlisted outputs are 0 in each state.
- **FETCH:** MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
- **DECODE:** ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) / 101011 (sw) → MEMADR
  - 000000 → RTYPE_EX
  - 000100 → BEQ
  - 001000 → ADDI_EX
  - 000010 → JUMP
  - anything else → ILLEGAL
- **MEMADR:** ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD for lw, MEMWR for sw (opcode held stable by IR).
- **MEMRD:** MemRead=1, IorD=1. Wait on mem_ready, then MEMWB.
- **MEMWB:** RegWrite=1, MemtoReg=1, RegDst=0 → FETCH.
- **MEMWR:** MemWrite=1, IorD=1. Wait on mem_ready, then FETCH.
- **RTYPE_EX:** ALUSrcA=1, ALUSrcB=00, ALUOp=10 → RTYPE_WB.
- **RTYPE_WB:** RegWrite=1, RegDst=1, MemtoReg=0 → FETCH.
- **BEQ:** ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 → FETCH.
- **ADDI_EX:** ALUSrcA=1, ALUSrcB=10, ALUOp=00 → ADDI_WB.
- **ADDI_WB:** RegWrite=1, RegDst=0, MemtoReg=0 → FETCH.
- **JUMP:** PCWrite=1, PCSource=10 → FETCH.
- **ILLEGAL:** illegal_op=1 for exactly this one cycle. Next state is FETCH if TRAP_ON_ILLEGAL=0, else HALT.
- **HALT:** halted=1, all other outputs 0. Exit only via reset.
- **Memory handshake:** in MEMRD/MEMWR/FETCH, MemRead/MemWrite stay asserted every wait cycle until mem_ready=1. A mem_ready pulse outside these states is ignored.
- **Latency in clocks with mem_ready=1:**
  - lw 5 (FETCH, DECODE, MEMADR, MEMRD, MEMWB)
  - sw, R-type, addi 4
  - beq, j 3
  - each mem_ready=0 cycle adds 1.
- **Unused encodings:** unused state encodings go to RESET-equivalent behaviour (outputs 0) and then FETCH.

Decomposition:
- Shared package/header `mips_defs`:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp codes
  - ALUSrcB and PCSource encodings
  - state encodings S_RESET…S_HALT (4-bit)
- One sub-module, `multicycle_next_state`: purely combinational (state, opcode, mem_ready) → next state. It is reused by the bench's reference model.
- The top level holds the state register and output decode.

Test Plan:
- **Reset and first fetch:** rst_n=0 for 3 cycles, release, mem_ready=1 → all outputs 0 during reset; cycle 1 RESET; cycle 2 FETCH with MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- **lw with wait states:** opcode=100011, mem_ready=0 for 2 cycles in MEMRD → MemRead, IorD held high 3 cycles; then MEMWB with RegWrite=1, MemtoReg=1, RegDst=0; total 7 cycles.
- **sw:** opcode=101011, mem_ready=1 → MemWrite=1, IorD=1 for exactly one cycle in MEMWR; FETCH 4 cycles after the first FETCH.
- **R-type then addi back-to-back:** ALUOp=10 in RTYPE_EX with RegDst=1 in RTYPE_WB; then ALUSrcB=10 in ADDI_EX with RegDst=0 in ADDI_WB; RegWrite=1 only in the WB states.
- **beq and j:** opcode=000100 → PCWriteCond=1, PCSource=01, ALUOp=01 in cycle 3; opcode=000010 → PCWrite=1, PCSource=10 in cycle 3.
- **Illegal opcode 111111 with TRAP_ON_ILLEGAL=0 and 1:** illegal_op high exactly one cycle. With 0, return to FETCH. With 1, halted=1 and outputs 0 for 20 cycles, cleared only by rst_n low.

Source files
------------

// File: rtl/mips_defs.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes,
// ALU control classes, datapath mux encodings and FSM state encodings.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Encoding 4'd15 is deliberately unused; it behaves like S_RESET.
    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTYPEEX = 4'd7,
        S_RTYPEWB = 4'd8,
        S_BEQ     = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12,
        S_ILLEGAL = 4'd13,
        S_HALT    = 4'd14
    } stateT;

endpackage

// File: rtl/multicycle_next_state.sv
// Combinational next-state function for the multi-cycle control FSM.
module multicycle_next_state
    import mips_defs::*;
#(
    parameter int OPCODE_W        = 6,
    parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
    input  logic [3:0]          state,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic [3:0]          nextState
);

    // Memory states hold until mem_ready; DECODE and MEMADR branch on opcode.
    always_comb begin
        nextState = S_FETCH;
        case (state)
            S_RESET:   nextState = S_FETCH;
            S_FETCH:   nextState = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nextState = S_MEMADR;
                    OP_RTYPE:     nextState = S_RTYPEEX;
                    OP_BEQ:       nextState = S_BEQ;
                    OP_ADDI:      nextState = S_ADDIEX;
                    OP_J:         nextState = S_JUMP;
                    default:      nextState = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  nextState = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   nextState = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   nextState = S_FETCH;
            S_MEMWR:   nextState = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: nextState = S_RTYPEWB;
            S_RTYPEWB: nextState = S_FETCH;
            S_BEQ:     nextState = S_FETCH;
            S_ADDIEX:  nextState = S_ADDIWB;
            S_ADDIWB:  nextState = S_FETCH;
            S_JUMP:    nextState = S_FETCH;
            S_ILLEGAL: nextState = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
            S_HALT:    nextState = S_HALT;
            default:   nextState = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: state register plus Moore output decode
// driving every mux select, enable and ALU class of the shared datapath.
module multicycle_control
    import mips_defs::*;
#(
    parameter int OPCODE_W        = 6,
    parameter int ALUOP_W         = 2,
    parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                IRWrite,
    output logic [1:0]          PCSource,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                illegal_op,
    output logic                halted,
    output logic [3:0]          state
);

    logic [3:0] stateReg;
    logic [3:0] nextState;

    multicycle_next_state #(
        .OPCODE_W        (OPCODE_W),
        .TRAP_ON_ILLEGAL (TRAP_ON_ILLEGAL)
    ) nextStateLogic (
        .state     (stateReg),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .nextState (nextState)
    );

    // State register; reset parks the FSM in RESET so all outputs drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= S_RESET;
        end else begin
            stateReg <= nextState;
        end
    end

    assign state = stateReg;

    // Moore decode from the registered state; only the FETCH IR/PC loads look at mem_ready.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUOp       = ALUOP_W'(ALUOP_ADD);
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        illegal_op  = 1'b0;
        halted      = 1'b0;
        case (stateReg)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMMSH2;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_RTYPEEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_W'(ALUOP_FUNCT);
            end
            S_RTYPEWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_W'(ALUOP_SUB);
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: one instance resumes after an
// illegal opcode, the other traps into HALT; both see identical stimulus.
module tb_multicycle_control;
    import mips_defs::*;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       memReady;

    logic       pcWrite0, pcWriteCond0, iorD0, memRead0, memWrite0, memtoReg0, irWrite0;
    logic [1:0] pcSource0, aluOp0, aluSrcB0;
    logic       aluSrcA0, regWrite0, regDst0, illegalOp0, halted0;
    logic [3:0] state0;

    logic       pcWrite1, pcWriteCond1, iorD1, memRead1, memWrite1, memtoReg1, irWrite1;
    logic [1:0] pcSource1, aluOp1, aluSrcB1;
    logic       aluSrcA1, regWrite1, regDst1, illegalOp1, halted1;
    logic [3:0] state1;

    logic [17:0] ctrl0, ctrl1;

    int checkCount = 0;
    int failCount  = 0;

    logic [17:0] cZero, cFetchRdy, cFetchWait, cDecode, cMemAdr, cMemRd, cMemWb, cMemWr;
    logic [17:0] cRtEx, cRtWb, cBeq, cAddiEx, cAddiWb, cJump, cIll, cHalt;

    multicycle_control #(.TRAP_ON_ILLEGAL(1'b0)) dutResume (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(memReady),
        .PCWrite(pcWrite0), .PCWriteCond(pcWriteCond0), .IorD(iorD0),
        .MemRead(memRead0), .MemWrite(memWrite0), .MemtoReg(memtoReg0),
        .IRWrite(irWrite0), .PCSource(pcSource0), .ALUOp(aluOp0),
        .ALUSrcA(aluSrcA0), .ALUSrcB(aluSrcB0), .RegWrite(regWrite0),
        .RegDst(regDst0), .illegal_op(illegalOp0), .halted(halted0), .state(state0)
    );

    multicycle_control #(.TRAP_ON_ILLEGAL(1'b1)) dutTrap (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(memReady),
        .PCWrite(pcWrite1), .PCWriteCond(pcWriteCond1), .IorD(iorD1),
        .MemRead(memRead1), .MemWrite(memWrite1), .MemtoReg(memtoReg1),
        .IRWrite(irWrite1), .PCSource(pcSource1), .ALUOp(aluOp1),
        .ALUSrcA(aluSrcA1), .ALUSrcB(aluSrcB1), .RegWrite(regWrite1),
        .RegDst(regDst1), .illegal_op(illegalOp1), .halted(halted1), .state(state1)
    );

    assign ctrl0 = {pcWrite0, pcWriteCond0, iorD0, memRead0, memWrite0, memtoReg0, irWrite0,
                    pcSource0, aluOp0, aluSrcA0, aluSrcB0, regWrite0, regDst0, illegalOp0, halted0};
    assign ctrl1 = {pcWrite1, pcWriteCond1, iorD1, memRead1, memWrite1, memtoReg1, irWrite1,
                    pcSource1, aluOp1, aluSrcA1, aluSrcB1, regWrite1, regDst1, illegalOp1, halted1};

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    function automatic logic [17:0] ctrlWord(
        input logic pcw, input logic pcwc, input logic iord, input logic mr, input logic mw,
        input logic m2r, input logic irw, input logic [1:0] pcs, input logic [1:0] aop,
        input logic srca, input logic [1:0] srcb, input logic rw, input logic rd,
        input logic ill, input logic hlt);
        return {pcw, pcwc, iord, mr, mw, m2r, irw, pcs, aop, srca, srcb, rw, rd, ill, hlt};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic mr, input logic [5:0] op);
        memReady = mr;
        opcode   = op;
    endtask

    // Drive one cycle's inputs, check both instances mid-cycle, then advance.
    task automatic expectCycle(input string tag, input logic mr, input logic [5:0] op,
                               input logic [3:0] expState, input logic [17:0] expCtrl);
        applyStimulus(mr, op);
        #1;
        checkOutput({tag, ".st0"}, 32'(state0), 32'(expState));
        checkOutput({tag, ".ctl0"}, 32'(ctrl0), 32'(expCtrl));
        checkOutput({tag, ".st1"}, 32'(state1), 32'(expState));
        checkOutput({tag, ".ctl1"}, 32'(ctrl1), 32'(expCtrl));
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        memReady = 1'b0;
        opcode   = 6'b0;

        cZero      = '0;
        cFetchRdy  = ctrlWord(1,0,0,1,0,0,1,2'b00,2'b00,0,2'b01,0,0,0,0);
        cFetchWait = ctrlWord(0,0,0,1,0,0,0,2'b00,2'b00,0,2'b01,0,0,0,0);
        cDecode    = ctrlWord(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b11,0,0,0,0);
        cMemAdr    = ctrlWord(0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0,0,0);
        cMemRd     = ctrlWord(0,0,1,1,0,0,0,2'b00,2'b00,0,2'b00,0,0,0,0);
        cMemWb     = ctrlWord(0,0,0,0,0,1,0,2'b00,2'b00,0,2'b00,1,0,0,0);
        cMemWr     = ctrlWord(0,0,1,0,1,0,0,2'b00,2'b00,0,2'b00,0,0,0,0);
        cRtEx      = ctrlWord(0,0,0,0,0,0,0,2'b00,2'b10,1,2'b00,0,0,0,0);
        cRtWb      = ctrlWord(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,1,1,0,0);
        cBeq       = ctrlWord(0,1,0,0,0,0,0,2'b01,2'b01,1,2'b00,0,0,0,0);
        cAddiEx    = ctrlWord(0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0,0,0);
        cAddiWb    = ctrlWord(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,1,0,0,0);
        cJump      = ctrlWord(1,0,0,0,0,0,0,2'b10,2'b00,0,2'b00,0,0,0,0);
        cIll       = ctrlWord(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,0,0,1,0);
        cHalt      = ctrlWord(0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,0,0,0,1);

        #1;
        for (int i = 0; i < 3; i++) expectCycle("rst.hold", 1'b1, 6'b100011, S_RESET, cZero);
        rst_n = 1'b1;
        expectCycle("rst.first",  1'b1, 6'b100011, S_RESET, cZero);
        expectCycle("fetch.wait", 1'b0, 6'b100011, S_FETCH, cFetchWait);
        expectCycle("fetch.rdy",  1'b1, 6'b100011, S_FETCH, cFetchRdy);

        expectCycle("lw.dec",   1'b1, 6'b100011, S_DECODE, cDecode);
        expectCycle("lw.adr",   1'b1, 6'b100011, S_MEMADR, cMemAdr);
        expectCycle("lw.rdw0",  1'b0, 6'b100011, S_MEMRD,  cMemRd);
        expectCycle("lw.rdw1",  1'b0, 6'b100011, S_MEMRD,  cMemRd);
        expectCycle("lw.rd",    1'b1, 6'b100011, S_MEMRD,  cMemRd);
        expectCycle("lw.wb",    1'b1, 6'b100011, S_MEMWB,  cMemWb);

        expectCycle("sw.fetch", 1'b1, 6'b101011, S_FETCH,  cFetchRdy);
        expectCycle("sw.dec",   1'b1, 6'b101011, S_DECODE, cDecode);
        expectCycle("sw.adr",   1'b1, 6'b101011, S_MEMADR, cMemAdr);
        expectCycle("sw.wr",    1'b1, 6'b101011, S_MEMWR,  cMemWr);

        expectCycle("rt.fetch", 1'b1, 6'b000000, S_FETCH,   cFetchRdy);
        expectCycle("rt.dec",   1'b1, 6'b000000, S_DECODE,  cDecode);
        expectCycle("rt.ex",    1'b1, 6'b000000, S_RTYPEEX, cRtEx);
        expectCycle("rt.wb",    1'b1, 6'b000000, S_RTYPEWB, cRtWb);
        expectCycle("ai.fetch", 1'b1, 6'b001000, S_FETCH,   cFetchRdy);
        expectCycle("ai.dec",   1'b0, 6'b001000, S_DECODE,  cDecode);
        expectCycle("ai.ex",    1'b0, 6'b001000, S_ADDIEX,  cAddiEx);
        expectCycle("ai.wb",    1'b1, 6'b001000, S_ADDIWB,  cAddiWb);

        expectCycle("beq.fetch", 1'b1, 6'b000100, S_FETCH,  cFetchRdy);
        expectCycle("beq.dec",   1'b0, 6'b000100, S_DECODE, cDecode);
        expectCycle("beq.ex",    1'b1, 6'b000100, S_BEQ,    cBeq);
        expectCycle("j.fetch",   1'b1, 6'b000010, S_FETCH,  cFetchRdy);
        expectCycle("j.dec",     1'b1, 6'b000010, S_DECODE, cDecode);
        expectCycle("j.ex",      1'b1, 6'b000010, S_JUMP,   cJump);

        expectCycle("ill.fetch", 1'b1, 6'b111111, S_FETCH,   cFetchRdy);
        expectCycle("ill.dec",   1'b1, 6'b111111, S_DECODE,  cDecode);
        expectCycle("ill.pulse", 1'b1, 6'b111111, S_ILLEGAL, cIll);

        applyStimulus(1'b1, 6'b111111);
        #1;
        checkOutput("ill.resume.st", 32'(state0), 32'(S_FETCH));
        checkOutput("ill.resume.ctl", 32'(ctrl0), 32'(cFetchRdy));
        checkOutput("ill.trap.st", 32'(state1), 32'(S_HALT));
        checkOutput("ill.trap.ctl", 32'(ctrl1), 32'(cHalt));
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'(i % 2), (i % 3 == 0) ? 6'b100011 : 6'b000000);
            #1;
            checkOutput("halt.st", 32'(state1), 32'(S_HALT));
            checkOutput("halt.ctl", 32'(ctrl1), 32'(cHalt));
            @(posedge clk);
            #1;
        end

        rst_n = 1'b0;
        #1;
        checkOutput("halt.rst.st", 32'(state1), 32'(S_RESET));
        checkOutput("halt.rst.ctl", 32'(ctrl1), 32'(cZero));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expectCycle("re.first", 1'b1, 6'b100011, S_RESET,  cZero);
        expectCycle("re.fetch", 1'b1, 6'b100011, S_FETCH,  cFetchRdy);
        expectCycle("re.dec",   1'b1, 6'b100011, S_DECODE, cDecode);
        expectCycle("re.adr",   1'b1, 6'b100011, S_MEMADR, cMemAdr);

        applyStimulus(1'b0, 6'b100011);
        #1;
        checkOutput("abort.pre", 32'(ctrl0), 32'(cMemRd));
        rst_n = 1'b0;
        #1;
        checkOutput("abort.st0", 32'(state0), 32'(S_RESET));
        checkOutput("abort.ctl0", 32'(ctrl0), 32'(cZero));
        checkOutput("abort.ctl1", 32'(ctrl1), 32'(cZero));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expectCycle("abort.first", 1'b1, 6'b100011, S_RESET, cZero);
        expectCycle("abort.fetch", 1'b1, 6'b100011, S_FETCH, cFetchRdy);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
